// File: rtl/frog_controller.sv
// Frog game controller: synchronised and debounced buttons, grid movement,
// lives/level bookkeeping and the PLAY/HIT/WIN/OVER state machine.
module frog_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FREEZE_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       collision,
  output logic [4:0] frog_col,
  output logic [3:0] frog_row,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic       frozen,
  output logic       game_over
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned FW = $clog2(FREEZE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FRZ_LAST = FW'(FREEZE_CYCLES - 1);
  localparam logic [4:0] START_COL = 5'd9;
  localparam logic [3:0] START_ROW = 4'd14;

  typedef enum logic [1:0] {PLAY, HIT, WIN, OVER} state_t;

  state_t        state;
  logic [3:0]    btn;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [3:0]    deb_q;
  logic [3:0]    move;
  logic [DW-1:0] cnt [4];
  logic [FW-1:0] freeze_cnt;
  logic [4:0]    next_col;
  logic [3:0]    next_row;

  // Bit 0 = up, 1 = down, 2 = left, 3 = right; lower index wins on ties.
  assign btn  = {btn_right, btn_left, btn_down, btn_up};
  assign move = deb & ~deb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == DEB_LAST) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    next_col = frog_col;
    next_row = frog_row;
    if (move[0]) begin
      if (frog_row != 4'd0) next_row = frog_row - 1'b1;
    end else if (move[1]) begin
      if (frog_row != 4'd14) next_row = frog_row + 1'b1;
    end else if (move[2]) begin
      if (frog_col != 5'd0) next_col = frog_col - 1'b1;
    end else if (move[3]) begin
      if (frog_col != 5'd19) next_col = frog_col + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PLAY;
      frog_col   <= START_COL;
      frog_row   <= START_ROW;
      lives      <= 2'd3;
      level      <= '0;
      frozen     <= 1'b0;
      game_over  <= 1'b0;
      freeze_cnt <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (collision) begin
            frog_col   <= START_COL;
            frog_row   <= START_ROW;
            frozen     <= 1'b1;
            freeze_cnt <= '0;
            if (lives > 2'd1) begin
              state <= HIT;
              lives <= lives - 1'b1;
            end else begin
              state     <= OVER;
              lives     <= '0;
              game_over <= 1'b1;
            end
          end else if (|move) begin
            frog_col <= next_col;
            frog_row <= next_row;
            if (next_row == 4'd0) begin
              state      <= WIN;
              frozen     <= 1'b1;
              freeze_cnt <= '0;
              if (level != 4'd15) level <= level + 1'b1;
            end
          end
        end
        HIT, WIN: begin
          if (freeze_cnt == FRZ_LAST) begin
            state  <= PLAY;
            frozen <= 1'b0;
            if (state == WIN) begin
              frog_col <= START_COL;
              frog_row <= START_ROW;
            end
          end else begin
            freeze_cnt <= freeze_cnt + 1'b1;
          end
        end
        OVER: begin
          if (|move) begin
            state     <= PLAY;
            frozen    <= 1'b0;
            game_over <= 1'b0;
            lives     <= 2'd3;
            level     <= '0;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule
